// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the framed-packet receiver.
package uart_frame_pkg;

  // Receiver states; IDLE is encoding 0 so a reset design reads back as 0.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  // Abort causes reported on err_code.
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CHK     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // States in which an input byte may be taken.
  function automatic logic state_takes_input(input state_e s);
    return (s == IDLE) || (s == LEN) || (s == PAYLOAD) || (s == CHK);
  endfunction

endpackage

// File: rtl/uart_frame_rx_buf.sv
// Payload store: MAX_LEN x 8 registers, synchronous write, asynchronous read.
module uart_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [IW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [MAX_LEN];

  // Storage has no reset; contents only matter after being written by a frame.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Framed-packet receiver: SOF / LEN / payload / XOR checksum, store-and-forward
// replay of the payload only when the checksum matches.
//
// Handshakes: a byte moves on in_data when in_valid & in_ready at a rising clk
// edge; a byte moves on out_data when out_valid & out_ready & ena at a rising
// edge. A presented out_data stays stable until it moves. in_ready never looks
// at in_valid.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int          MAX_LEN        = 16,
  parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int AW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  state_e          state_q;
  err_code_e       err_code_q;
  logic [AW-1:0]   len_q;
  logic [AW-1:0]   wr_idx_q;
  logic [AW-1:0]   rd_idx_q;
  logic [7:0]      chk_q;
  logic [TW-1:0]   tmo_q;
  logic [7:0]      out_data_q;
  logic            out_valid_q;
  logic            frame_ok_q;
  logic            frame_err_q;

  logic            accept;
  logic            xfer;
  logic            buf_we;
  logic [IW-1:0]   buf_waddr;
  logic [IW-1:0]   buf_raddr;
  logic [7:0]      buf_rdata;

  // rst_n gating keeps in_ready low for the whole reset, even with ena high.
  assign in_ready = rst_n & ena & state_takes_input(state_q);
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid_q & out_ready & ena;

  // Read address looks one byte ahead in DRAIN so out_data can be registered;
  // outside DRAIN it points at byte 0, ready for the checksum-accept edge.
  assign buf_we    = accept && (state_q == PAYLOAD);
  assign buf_waddr = IW'(wr_idx_q);
  assign buf_raddr = (state_q == DRAIN) ? IW'(rd_idx_q + 1'b1) : '0;

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .IW      (IW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (in_data),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  // Frame FSM with its counters and registered outputs; pulses self-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      err_code_q  <= ERR_NONE;
      len_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      chk_q       <= '0;
      tmo_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (ena) begin
        unique case (state_q)
          IDLE: begin
            if (accept && (in_data == SOF_BYTE)) begin
              state_q <= LEN;
              tmo_q   <= '0;
            end
          end
          LEN, PAYLOAD, CHK: begin
            if (accept) begin
              tmo_q <= '0;
              if (state_q == LEN) begin
                if ((in_data == 8'd0) || (in_data > MAX_LEN_B)) begin
                  state_q     <= IDLE;
                  frame_err_q <= 1'b1;
                  err_code_q  <= ERR_LEN;
                end else begin
                  len_q    <= AW'(in_data);
                  chk_q    <= in_data;
                  wr_idx_q <= '0;
                  state_q  <= PAYLOAD;
                end
              end else if (state_q == PAYLOAD) begin
                chk_q    <= chk_q ^ in_data;
                wr_idx_q <= wr_idx_q + 1'b1;
                if (wr_idx_q == len_q - 1'b1) state_q <= CHK;
              end else begin
                if (in_data == chk_q) begin
                  state_q     <= DRAIN;
                  frame_ok_q  <= 1'b1;
                  rd_idx_q    <= '0;
                  out_valid_q <= 1'b1;
                  out_data_q  <= buf_rdata;
                end else begin
                  state_q     <= IDLE;
                  frame_err_q <= 1'b1;
                  err_code_q  <= ERR_CHK;
                end
              end
            end else if (tmo_q >= TMO_LAST) begin
              // This idle cycle is the TIMEOUT_CYCLES-th one in a row.
              state_q     <= IDLE;
              tmo_q       <= '0;
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_TIMEOUT;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          DRAIN: begin
            if (xfer) begin
              if (rd_idx_q == len_q - 1'b1) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
              end else begin
                rd_idx_q   <= rd_idx_q + 1'b1;
                out_data_q <= buf_rdata;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Framed-packet receiver sitting directly downstream of the UART RX byte stream (rx_data/rx_valid/rx_ready) and upstream of the UART TX byte stream.
- Hunts for a start-of-frame byte, then collects a length byte, the payload and an XOR checksum.
- Stores the payload in an internal buffer and, only on a good checksum, replays the payload on a valid/ready output stream (store-and-forward).
- Reports malformed frames through error pulses and a code.

Parameters:
- MAX_LEN, 16: maximum payload bytes per frame (buffer depth), 1..255.
- SOF_BYTE, 8'hA5: start-of-frame marker.
- TIMEOUT_CYCLES, 50_000: enabled cycles without an accepted byte mid-frame before the frame aborts (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- ena  input  1  global enable; low freezes all state
- in_data  input  8  byte from UART RX
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- out_data  output  8  payload byte toward UART TX
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- frame_ok  output  1  one-cycle pulse: good frame received
- frame_err  output  1  one-cycle pulse: frame aborted
- err_code  output  2  cause of last abort; held until next abort
- busy  output  1  state != IDLE

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, port rst_n.
- Reset: state IDLE. in_ready=0 during reset; out_valid=0, frame_ok=0, frame_err=0, err_code=0, busy=0, all counters 0. Buffer contents are not cleared (don't-care).
- Accept: accept = in_valid & in_ready. Output transfer: xfer = out_valid & out_ready & ena.
- in_ready = ena & (state in {IDLE, LEN, PAYLOAD, CHK}). It is combinational from state and ena only, with no dependence on in_valid.
- ena=0: no state, counter or buffer change. Pulses are not generated. out_valid and out_data hold their values.
- IDLE: on accept, a byte == SOF_BYTE moves to LEN. Any other byte is discarded silently, with no error.
- LEN: on accept, byte==0 or byte>MAX_LEN raises an error with err_code=1 (LEN) and moves to IDLE. Otherwise len<=byte, chk<=byte, wr_idx<=0, and the state moves to PAYLOAD.
- PAYLOAD: on accept, buf[wr_idx]<=byte, chk<=chk^byte, wr_idx++. When wr_idx==len-1 the state moves to CHK.
- PAYLOAD data rule: SOF_BYTE inside the payload is plain data; there is no resync.
- CHK: on accept, byte==chk moves to DRAIN, with frame_ok=1 for one cycle and rd_idx<=0. Otherwise the block raises an error with err_code=2 (CHK) and moves to IDLE.
- DRAIN: out_valid=1, out_data=buf[rd_idx]. On xfer, rd_idx++. If rd_idx==len-1, the next state is IDLE and out_valid drops.
- DRAIN stability: out_data stays stable while out_valid & !out_ready. Outputs are registered.
- Latency: frame_ok and the first out_valid assert on the clock edge that accepts the CHK byte, i.e. visible the cycle after acceptance. The whole frame drains in len cycles when out_ready is held high.
- Timeout: a counter runs in LEN/PAYLOAD/CHK. It clears on every accept and increments on each enabled cycle without an accept.
- Timeout trigger: when the counter reaches TIMEOUT_CYCLES, the block raises an error with err_code=3 (TIMEOUT) and moves to IDLE. The counter is inactive in IDLE/DRAIN.
- Error action: frame_err=1 for one cycle, err_code updated, state moves to IDLE, partial payload discarded, and out_valid stays 0.
- Back-to-back frames: after the last drained byte, the block is in IDLE and can accept the next SOF on the following cycle. No bytes are accepted during DRAIN; upstream holds them.
- Reset mid-frame or mid-drain: asynchronous return to IDLE. out_valid drops immediately and the frame is lost.
- Widths: len and indices use $clog2(MAX_LEN+1) bits. The timeout counter uses $clog2(TIMEOUT_CYCLES+1) bits and saturates.

Decomposition:
- uart_frame_pkg contains:
  - state enum {IDLE, LEN, PAYLOAD, CHK, DRAIN};
  - err_code enum {ERR_NONE=0, ERR_LEN=1, ERR_CHK=2, ERR_TIMEOUT=3};
  - default SOF constant 8'hA5.
- One sub-module, uart_frame_buf: MAX_LEN x 8 register array with a synchronous write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata). No reset on storage.

Test Plan:
- Bench parameters: MAX_LEN=16 and TIMEOUT_CYCLES=100 (overridden for simulation).
- Good frame: A5 03 11 22 33 03 with out_ready=1 -> frame_ok pulse once; out stream 11,22,33 on consecutive cycles; frame_err never asserts; busy low after the last byte.
- Garbage and bad length: 00 FF A5 00 -> the first two bytes are discarded silently; then frame_err with err_code=1. Repeat with A5 11 (17 > MAX_LEN) -> err_code=1.
- Bad checksum: A5 02 AA 55 00 (correct is FD) -> frame_err, err_code=2, out_valid never asserts; a following good frame A5 01 7E 7F -> out 7E.
- Backpressure: good frame with out_ready toggling 1,0,0,1,... -> every byte is delivered once, in order; out_data stays stable while stalled; in_ready=0 throughout DRAIN.
- Timeout and ena: A5 02 10, then idle for 100 cycles -> frame_err, err_code=3. Separately, holding ena=0 for 500 cycles mid-frame -> no timeout, and the frame completes normally after ena returns.
- Reset mid-drain: assert rst_n=0 while out_valid=1 -> out_valid, busy and frame_ok go to 0 without waiting for a clk edge; after release, a new good frame A5 01 42 43 -> out 42.
